// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// A granted byte is latched into tx_din and launched with a one-cycle tx_start;
// the next grant waits for tx_done_tick. A byte with last=0 locks the
// transmitter to its owner until that owner's last=1 byte is granted.
module uart_tx_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DBIT = 8,
    parameter int unsigned GW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 locked
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            locked_q, locked_d;
    logic [DBIT-1:0] din_q, din_d;

    logic            win_found;
    logic [GW-1:0]   win_idx;
    int unsigned     cand;
    logic [GW-1:0]   cand_idx;

    // Pick the winner: the frame owner while locked, otherwise the first valid
    // requester after ptr, wrapping modulo NREQ (NREQ need not be a power of 2).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        if (locked_q) begin
            win_found = req_valid[grant_q];
            win_idx   = grant_q;
        end else begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                cand_idx = GW'(cand);
                if (!win_found && req_valid[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        locked_d  = locked_q;
        din_d     = din_q;
        tx_start  = 1'b0;
        req_ready = '0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    din_d    = req_data[win_idx*DBIT +: DBIT];
                    grant_d  = win_idx;
                    ptr_d    = win_idx;
                    locked_d = ~req_last[win_idx];
                    state_d  = START;
                end
            end
            START: begin
                tx_start           = 1'b1;
                req_ready[grant_q] = 1'b1;
                state_d            = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= GW'(NREQ - 1);
            grant_q  <= '0;
            locked_q <= 1'b0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
            din_q    <= din_d;
        end
    end

    assign tx_din   = din_q;
    assign grant_id = grant_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by a
// randomized phase, checked against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DBIT = 8;
    localparam int GW   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_last;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_din;
    logic                 tx_done_tick;
    logic                 busy;
    logic [GW-1:0]        grant_id;
    logic                 locked;

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .GW(GW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the transmitter and where round-robin resumes.
    int         m_ptr;
    int         m_owner;
    bit         m_locked;
    logic [7:0] m_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_winner(input logic [NREQ-1:0] v);
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr    = NREQ - 1;
        m_owner  = 0;
        m_locked = 1'b0;
        m_din    = 8'h00;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
        req_valid[i]              = v;
        req_data[i*DBIT +: DBIT]  = d;
        req_last[i]               = l;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        model_reset();
    endtask

    // One IDLE-cycle evaluation: inputs are already set at this negedge.
    task automatic idle_step(input string tag, output int g);
        logic [7:0] d;
        bit         l;
        d = 8'h00;
        l = 1'b0;
        g = exp_winner(req_valid);
        if (g >= 0) begin
            d = req_data[g*DBIT +: DBIT];
            l = req_last[g];
        end
        cyc();
        if (g < 0) begin
            chk({tag, "_nostart"}, tx_start, 0);
            chk({tag, "_noready"}, req_ready, 0);
            chk({tag, "_idlebusy"}, busy, 0);
        end else begin
            m_ptr    = g;
            m_owner  = g;
            m_locked = !l;
            m_din    = d;
            chk({tag, "_start"}, tx_start, 1);
            chk({tag, "_ready"}, req_ready, 32'(1) << g);
            chk({tag, "_din"}, tx_din, m_din);
            chk({tag, "_gid"}, grant_id, m_owner);
            chk({tag, "_locked"}, locked, m_locked);
            chk({tag, "_busy"}, busy, 1);
        end
    endtask

    // Called at the START negedge: run WAIT for d extra cycles, then done.
    task automatic finish_tx(input string tag, input int d, input bit spur);
        tx_done_tick = spur;
        cyc();
        tx_done_tick = 1'b0;
        chk({tag, "_waitbusy"}, busy, 1);
        chk({tag, "_waitstart"}, tx_start, 0);
        chk({tag, "_waitready"}, req_ready, 0);
        repeat (d) cyc();
        chk({tag, "_stillwait"}, busy, 1);
        chk({tag, "_nostart2"}, tx_start, 0);
        tx_done_tick = 1'b1;
        cyc();
        tx_done_tick = 1'b0;
        chk({tag, "_donebusy"}, busy, 0);
        chk({tag, "_donestart"}, tx_start, 0);
        chk({tag, "_holddin"}, tx_din, m_din);
        chk({tag, "_holdlock"}, locked, m_locked);
        chk({tag, "_holdgid"}, grant_id, m_owner);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         g;
        int         rr_order[5];
        logic [7:0] fbytes[3];
        bit         flast[3];
        logic [7:0] rd;

        rr_order = '{0, 1, 2, 3, 0};
        fbytes   = '{8'h11, 8'h22, 8'h33};
        flast    = '{1'b0, 1'b0, 1'b1};

        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        tx_done_tick = 1'b0;
        reset        = 1'b0;
        model_reset();
        repeat (2) cyc();
        reset = 1'b1;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_din", tx_din, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_locked", locked, 0);

        // Single request
        set_req(0, 1'b1, 8'hA5, 1'b1);
        idle_step("single", g);
        chk("single_din_const", tx_din, 8'hA5);
        chk("single_ready_const", req_ready, 4'b0001);
        set_req(0, 1'b0, 8'h00, 1'b0);
        finish_tx("single", 5, 1'b0);

        // Round-robin from a fresh reset, all valid, done ~20 cycles after start
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(8'h40 + i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            idle_step("rr", g);
            chk("rr_order", grant_id, rr_order[k]);
            chk("rr_din", tx_din, 8'(8'h40 + rr_order[k]));
            finish_tx("rr", 18, 1'b0);
        end
        req_valid = '0;

        // Frame lock: requester 2 sends a 3-byte frame while 0 stays valid
        set_req(0, 1'b1, 8'h77, 1'b1);
        for (int k = 0; k < 3; k++) begin
            set_req(2, 1'b1, fbytes[k], flast[k]);
            idle_step("frame", g);
            chk("frame_gid", grant_id, 2);
            chk("frame_din", tx_din, fbytes[k]);
            chk("frame_lock", locked, (k < 2) ? 1 : 0);
            finish_tx("frame", 3, 1'b0);
        end
        set_req(2, 1'b0, 8'h00, 1'b0);
        idle_step("frame_next", g);
        chk("frame_next_gid", grant_id, 0);
        chk("frame_next_din", tx_din, 8'h77);
        set_req(0, 1'b0, 8'h00, 1'b0);
        finish_tx("frame_next", 2, 1'b0);

        // Owner stall: locked to 1, owner drops valid while 3 is valid
        set_req(1, 1'b1, 8'hB1, 1'b0);
        set_req(3, 1'b1, 8'h3C, 1'b1);
        idle_step("stall_lock", g);
        chk("stall_lock_gid", grant_id, 1);
        chk("stall_lock_locked", locked, 1);
        finish_tx("stall_lock", 2, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 50; k++) idle_step("stall", g);
        chk("stall_gid", grant_id, 1);
        chk("stall_locked", locked, 1);
        set_req(1, 1'b1, 8'hB2, 1'b1);
        idle_step("stall_resume", g);
        chk("stall_resume_gid", grant_id, 1);
        chk("stall_resume_din", tx_din, 8'hB2);
        chk("stall_resume_unlock", locked, 0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        finish_tx("stall_resume", 2, 1'b0);
        idle_step("stall_after", g);
        chk("stall_after_gid", grant_id, 3);
        set_req(3, 1'b0, 8'h00, 1'b0);
        // Spurious done during START
        finish_tx("spur_start", 2, 1'b1);

        // Spurious done in IDLE
        tx_done_tick = 1'b1;
        idle_step("spur_idle", g);
        tx_done_tick = 1'b0;
        idle_step("spur_idle2", g);
        chk("spur_idle_din", tx_din, 8'h3C);

        // Reset mid-WAIT while locked
        set_req(2, 1'b1, 8'h5A, 1'b0);
        idle_step("rstw", g);
        chk("rstw_locked", locked, 1);
        set_req(2, 1'b0, 8'h00, 1'b0);
        cyc();
        chk("rstw_inwait", busy, 1);
        reset = 1'b0;
        set_req(1, 1'b1, 8'hC1, 1'b1);
        set_req(3, 1'b1, 8'hC3, 1'b1);
        cyc();
        reset = 1'b1;
        model_reset();
        chk("rstw_busy", busy, 0);
        chk("rstw_locked0", locked, 0);
        chk("rstw_gid", grant_id, 0);
        chk("rstw_start", tx_start, 0);
        chk("rstw_ready", req_ready, 0);
        idle_step("rstw_post", g);
        chk("rstw_post_gid", grant_id, 1);
        set_req(1, 1'b0, 8'h00, 1'b0);
        finish_tx("rstw_post", 1, 1'b0);
        set_req(3, 1'b0, 8'h00, 1'b0);

        // Randomized phase
        g = -1;
        for (int it = 0; it < 150; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                rd = 8'($urandom);
                if (i == g || !req_valid[i]) begin
                    set_req(i, $urandom_range(0, 3) != 0, rd, $urandom_range(0, 2) != 0);
                end else if ($urandom_range(0, 9) == 0) begin
                    set_req(i, 1'b0, rd, 1'b0);
                end
            end
            tx_done_tick = ($urandom_range(0, 7) == 0);
            idle_step("rnd", g);
            tx_done_tick = 1'b0;
            if (g >= 0) finish_tx("rnd", $urandom_range(0, 5), $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
